// File: rtl/fetch_prefetcher.sv
// fetch_prefetcher: instruction-fetch front end.
//   Issues word-aligned requests on a req/gnt/rvalid bus and pushes responses into
//   a small registered skid FIFO. The FIFO feeds the downstream realign buffer.
//   A redirect clears the buffer, flushes the skid and squashes in-flight responses.
//   Request credit covers granted requests, queued skid entries and pending squashes,
//   so the skid can never overflow.
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   fetch_en_i                        core allows fetching
//   redirect_i, redirect_addr_i       one-cycle redirect strobe and new halfword PC
//   instr_req_o, instr_addr_o         memory request and word address
//   instr_gnt_i                       memory accepted the request
//   instr_rvalid_i, instr_rdata_i     in-order response
//   buf_clear_o, buf_read_offset_o    realign buffer clear and halfword offset
//   buf_write_en_o, buf_instr_o,
//   buf_addr_o                        skid head written into the buffer
//   buf_full_i                        buffer cannot accept a word
//   perf_stall_cnt_o,
//   perf_discard_cnt_o                optional counters, present when FETCH_PERF_CNT_EN is defined
module fetch_prefetcher #(
   parameter int unsigned RISCV_ADDR_WIDTH = 32,
   parameter int unsigned RISCV_WORD_WIDTH = 32,
   parameter int unsigned MAX_OUTSTANDING  = 2,
   parameter logic [RISCV_ADDR_WIDTH-1:0] BOOT_ADDR = '0
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        fetch_en_i,
   input  logic                        redirect_i,
   input  logic [RISCV_ADDR_WIDTH-1:0] redirect_addr_i,
   output logic                        instr_req_o,
   output logic [RISCV_ADDR_WIDTH-1:0] instr_addr_o,
   input  logic                        instr_gnt_i,
   input  logic                        instr_rvalid_i,
   input  logic [RISCV_WORD_WIDTH-1:0] instr_rdata_i,
   output logic                        buf_clear_o,
   output logic                        buf_read_offset_o,
   output logic                        buf_write_en_o,
   output logic [RISCV_WORD_WIDTH-1:0] buf_instr_o,
   output logic [RISCV_ADDR_WIDTH-1:0] buf_addr_o,
   input  logic                        buf_full_i
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0]                 perf_stall_cnt_o,
   output logic [31:0]                 perf_discard_cnt_o
`endif
);

   localparam int unsigned AW = RISCV_ADDR_WIDTH;
   localparam int unsigned WW = RISCV_WORD_WIDTH;
   localparam logic [3:0] MaxOut  = 4'(MAX_OUTSTANDING);
   localparam logic [1:0] LastPtr = 2'(MAX_OUTSTANDING - 1);

   typedef enum logic [1:0] {StIdle, StRun, StSquash} state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   fetch_addr_q, fetch_addr_d;
   logic [2:0]      outstanding_q, outstanding_d;
   logic [2:0]      discard_q, discard_d;
   logic [2:0]      skid_cnt_q, skid_cnt_d;
   logic [1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [WW-1:0]   skid_data_q [4];
   logic [AW-1:0]   skid_addr_q [4];

   logic [3:0]      credit_sum;
   logic [3:0]      in_flight;
   logic            grant, drop, push, pop;
   logic [AW-1:0]   resp_addr;
   logic            unused_addr_bit;

   assign unused_addr_bit = redirect_addr_i[0];

   function automatic logic [1:0] ptr_inc(input logic [1:0] p);
      return (p == LastPtr) ? 2'd0 : p + 2'd1;
   endfunction

   assign credit_sum  = {1'b0, outstanding_q} + {1'b0, skid_cnt_q} + {1'b0, discard_q};
   assign instr_req_o = fetch_en_i & ~redirect_i & (credit_sum < MaxOut);
   assign instr_addr_o = fetch_addr_q;
   assign grant = instr_req_o & instr_gnt_i;
   assign drop  = instr_rvalid_i & (discard_q != 3'd0);
   assign push  = instr_rvalid_i & (discard_q == 3'd0) & ~redirect_i;
   assign pop   = (skid_cnt_q != 3'd0) & ~buf_full_i & ~redirect_i;

   // Responses are in order, so the oldest live request sits `outstanding` words behind.
   assign resp_addr = fetch_addr_q - AW'({outstanding_q, 2'b00});

   assign buf_clear_o       = redirect_i;
   assign buf_read_offset_o = redirect_i & redirect_addr_i[1];
   assign buf_write_en_o    = pop;
   assign buf_instr_o       = skid_data_q[rd_ptr_q];
   assign buf_addr_o        = skid_addr_q[rd_ptr_q];

   // Everything still on the bus after a redirect becomes a pending squash.
   assign in_flight = {1'b0, outstanding_q} + {1'b0, discard_q};

   always_comb begin
      fetch_addr_d  = fetch_addr_q;
      outstanding_d = outstanding_q;
      discard_d     = discard_q;
      skid_cnt_d    = skid_cnt_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      if (redirect_i) begin
         fetch_addr_d  = {redirect_addr_i[AW-1:2], 2'b00};
         outstanding_d = 3'd0;
         skid_cnt_d    = 3'd0;
         wr_ptr_d      = 2'd0;
         rd_ptr_d      = 2'd0;
         if (instr_rvalid_i && in_flight != 4'd0) begin
            discard_d = (in_flight - 4'd1 > MaxOut) ? MaxOut[2:0] : 3'(in_flight - 4'd1);
         end else begin
            discard_d = (in_flight > MaxOut) ? MaxOut[2:0] : in_flight[2:0];
         end
      end else begin
         if (grant) fetch_addr_d = fetch_addr_q + AW'(4);
         outstanding_d = outstanding_q + {2'b00, grant} - {2'b00, push};
         discard_d     = discard_q - {2'b00, drop};
         skid_cnt_d    = skid_cnt_q + {2'b00, push} - {2'b00, pop};
         if (push) wr_ptr_d = ptr_inc(wr_ptr_q);
         if (pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (fetch_en_i) state_d = (discard_d != 3'd0) ? StSquash : StRun;
         end
         StRun: begin
            if (!fetch_en_i)             state_d = StIdle;
            else if (discard_d != 3'd0)  state_d = StSquash;
         end
         StSquash: begin
            if (!fetch_en_i)             state_d = StIdle;
            else if (discard_d == 3'd0)  state_d = StRun;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= StIdle;
         fetch_addr_q  <= {BOOT_ADDR[AW-1:2], 2'b00};
         outstanding_q <= 3'd0;
         discard_q     <= 3'd0;
         skid_cnt_q    <= 3'd0;
         wr_ptr_q      <= 2'd0;
         rd_ptr_q      <= 2'd0;
      end else begin
         state_q       <= state_d;
         fetch_addr_q  <= fetch_addr_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         skid_cnt_q    <= skid_cnt_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++) begin
            skid_data_q[i] <= '0;
            skid_addr_q[i] <= '0;
         end
      end else if (push) begin
         skid_data_q[wr_ptr_q] <= instr_rdata_i;
         skid_addr_q[wr_ptr_q] <= resp_addr;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] stall_cnt_q, discard_cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt_q   <= 32'd0;
         discard_cnt_q <= 32'd0;
      end else begin
         if (instr_req_o && !instr_gnt_i) stall_cnt_q <= stall_cnt_q + 32'd1;
         // A response in the redirect cycle is squashed as well.
         if (instr_rvalid_i && (redirect_i || discard_q != 3'd0)) begin
            discard_cnt_q <= discard_cnt_q + 32'd1;
         end
      end
   end

   assign perf_stall_cnt_o   = stall_cnt_q;
   assign perf_discard_cnt_o = discard_cnt_q;
`endif

endmodule
